fft32_bitrev_reorder: RTL and testbench



---
 rtl/fft32_bitrev_reorder.sv | 91 +++++++++
 tb/tb_fft32_bitrev_reorder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft32_bitrev_reorder.sv
// Output reorder buffer for the 32-point SDF FFT. It captures bit-reversed frames into a
// ping-pong memory and replays each one in natural order with its bin index.
module fft32_bitrev_reorder #(
  parameter int unsigned N     = 32,
  parameter int unsigned LOG2N = 5,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_in_r,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_out_r,
  output logic [WIDTH-1:0] data_out_i,
  output logic [LOG2N-1:0] index_o,
  output logic             frame_start_o
);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < int'(LOG2N); b++) begin
      r[b] = a[int'(LOG2N) - 1 - b];
    end
    return r;
  endfunction

  logic [2*WIDTH-1:0] mem [2][N];

  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic [LOG2N-1:0] rd_cnt;
  logic             rd_bank;
  logic             rd_active;
  logic             wr_last;
  logic             rd_last;

  assign wr_last = valid_i && (wr_cnt == LOG2N'(N - 1));
  assign rd_last = rd_cnt == LOG2N'(N - 1);

  // Storage is deliberately not reset; a write during reset is harmless but suppressed anyway.
  always_ff @(posedge clk) begin
    if (valid_i && !rst) begin
      mem[wr_bank][bitrev(wr_cnt)] <= {data_in_r, data_in_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt        <= '0;
      wr_bank       <= 1'b0;
      rd_cnt        <= '0;
      rd_bank       <= 1'b0;
      rd_active     <= 1'b0;
      valid_o       <= 1'b0;
      frame_start_o <= 1'b0;
      data_out_r    <= '0;
      data_out_i    <= '0;
      index_o       <= '0;
    end else begin
      if (valid_i) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) begin
          wr_bank <= ~wr_bank;
        end
      end

      if (rd_active) begin
        {data_out_r, data_out_i} <= mem[rd_bank][rd_cnt];
        index_o                  <= rd_cnt;
        valid_o                  <= 1'b1;
        frame_start_o            <= (rd_cnt == '0);
        rd_cnt                   <= rd_cnt + 1'b1;
        if (rd_last) begin
          rd_active <= 1'b0;
        end
      end else begin
        valid_o       <= 1'b0;
        frame_start_o <= 1'b0;
      end

      // A completing frame overrides the read-side update, so back-to-back frames have no bubble.
      if (wr_last) begin
        rd_bank   <= wr_bank;
        rd_cnt    <= '0;
        rd_active <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft32_bitrev_reorder.sv
// Directed bench for fft32_bitrev_reorder: table-driven frames plus reset and back-to-back
// sequences, with every output beat captured by a monitor and compared to bench expectations.
module tb_fft32_bitrev_reorder;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i;
  logic [WIDTH-1:0] data_in_r;
  logic [WIDTH-1:0] data_in_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] data_out_i;
  logic [LOG2N-1:0] index_o;
  logic             frame_start_o;

  fft32_bitrev_reorder #(.N(N), .LOG2N(LOG2N), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .data_in_r    (data_in_r),
    .data_in_i    (data_in_i),
    .valid_o      (valid_o),
    .data_out_r   (data_out_r),
    .data_out_i   (data_out_i),
    .index_o      (index_o),
    .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [4:0]  idx;
    logic [15:0] r;
    logic [15:0] i;
    logic        fs;
  } cap_t;
  cap_t cap[$];

  always @(negedge clk) begin
    if (valid_o === 1'b1) cap.push_back('{cyc, index_o, data_out_r, data_out_i, frame_start_o});
  end

  typedef struct {
    logic [15:0] in_r;
    logic [15:0] in_i;
    logic [15:0] exp_r;
    logic [15:0] exp_i;
  } vec_t;
  vec_t tbl[32];

  logic [15:0] xr[64];
  logic [15:0] xi[64];
  int nexp;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] br(input int v);
    logic [4:0] a;
    logic [4:0] r;
    a = v[4:0];
    for (int b = 0; b < 5; b++) r[b] = a[4-b];
    return r;
  endfunction

  task automatic send(input logic v, input logic [15:0] r, input logic [15:0] i, output int e_n);
    valid_i   = v;
    data_in_r = r;
    data_in_i = i;
    @(posedge clk);
    #1;
    e_n     = cyc;
    valid_i = 1'b0;
  endtask

  // Feed the table as one contiguous frame and load its expected outputs.
  task automatic feed_tbl(output int e_last);
    int e;
    for (int w = 0; w < 32; w++) begin
      send(1'b1, tbl[w].in_r, tbl[w].in_i, e);
      xr[w] = tbl[w].exp_r;
      xi[w] = tbl[w].exp_i;
    end
    nexp   = 32;
    e_last = e;
  endtask

  task automatic verify(input string name, input int first);
    repeat (nexp + 4) @(negedge clk);
    #1;
    chk({name, " beat count"}, cap.size(), nexp);
    for (int j = 0; j < nexp && j < cap.size(); j++) begin
      chk($sformatf("%s[%0d] cycle", name, j), cap[j].c, first + 1 + j);
      chk($sformatf("%s[%0d] index", name, j), {27'd0, cap[j].idx}, j % 32);
      chk($sformatf("%s[%0d] re", name, j), {16'd0, cap[j].r}, {16'd0, xr[j]});
      chk($sformatf("%s[%0d] im", name, j), {16'd0, cap[j].i}, {16'd0, xi[j]});
      chk($sformatf("%s[%0d] frame_start", name, j), {31'd0, cap[j].fs}, (j % 32) == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int e_a;
    int d;
    int hits;

    // Reset held for two cycles while samples are presented.
    rst = 1'b1;
    valid_i = 1'b1;
    data_in_r = 16'h1234;
    data_in_i = 16'h4321;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid_o", valid_o, 0);
    chk("reset data_out_r", data_out_r, 0);
    chk("reset data_out_i", data_out_i, 0);
    chk("reset index_o", index_o, 0);
    chk("reset frame_start_o", frame_start_o, 0);
    rst = 1'b0;
    valid_i = 1'b0;
    chk("reset no output", cap.size(), 0);

    // Single frame: re=w, im=-w.
    for (int w = 0; w < 32; w++) begin
      tbl[w].in_r  = 16'(w);
      tbl[w].in_i  = 16'(-w);
      tbl[w].exp_r = 16'(br(w));
      tbl[w].exp_i = 16'(-int'(br(w)));
    end
    feed_tbl(e);
    verify("single", e);
    if (cap.size() == 32) begin
      chk("single bin1 re", cap[1].r, 16);
      chk("single bin3 re", cap[3].r, 24);
      chk("single bin31 re", cap[31].r, 31);
      chk("single bin3 im", cap[3].i, 16'hFFE8);
    end
    cap.delete();

    // Back-to-back frames A (w) and B (100+w) with continuous valid.
    for (int w = 0; w < 32; w++) begin
      send(1'b1, 16'(w), 16'(50 + w), e_a);
      xr[w] = 16'(br(w));
      xi[w] = 16'(50 + br(w));
    end
    for (int w = 0; w < 32; w++) begin
      send(1'b1, 16'(100 + w), 16'(150 + w), e);
      xr[32+w] = 16'(100 + br(w));
      xi[32+w] = 16'(150 + br(w));
    end
    nexp = 64;
    verify("b2b", e_a);
    if (cap.size() == 64) begin
      chk("b2b B bin1 re", cap[33].r, 116);
      chk("b2b wrap index", cap[32].idx, 0);
      chk("b2b wrap frame_start", cap[32].fs, 1);
    end
    cap.delete();

    // Gapped input with poison on the idle cycles.
    for (int w = 0; w < 32; w++) begin
      send(1'b1, 16'(w), 16'(1000 + w), e);
      xr[w] = 16'(br(w));
      xi[w] = 16'(1000 + br(w));
      if (w != 31) send(1'b0, 16'h7FFF, 16'h7FFF, d);
    end
    nexp = 32;
    verify("gapped", e);
    hits = 0;
    foreach (cap[j]) if (cap[j].r == 16'h7FFF || cap[j].i == 16'h7FFF) hits++;
    chk("gapped poison seen", hits, 0);
    cap.delete();

    // Signed extremes.
    for (int w = 0; w < 32; w++) begin
      case (w % 4)
        0: begin tbl[w].in_r = 16'h8000; tbl[w].in_i = 16'h7FFF; end
        1: begin tbl[w].in_r = 16'h7FFF; tbl[w].in_i = 16'h8000; end
        2: begin tbl[w].in_r = 16'h8000 + 16'(w); tbl[w].in_i = 16'h7FFF - 16'(w); end
        default: begin tbl[w].in_r = 16'h7FFF - 16'(w); tbl[w].in_i = 16'h8000 + 16'(w); end
      endcase
    end
    for (int k = 0; k < 32; k++) begin
      tbl[k].exp_r = tbl[br(k)].in_r;
      tbl[k].exp_i = tbl[br(k)].in_i;
    end
    feed_tbl(e);
    verify("extremes", e);
    cap.delete();

    // Reset mid-frame: partial frame is discarded, rst wins over valid_i.
    for (int w = 0; w < 10; w++) send(1'b1, 16'(500 + w), 16'(600 + w), d);
    rst = 1'b1;
    send(1'b1, 16'h1111, 16'h1111, d);
    rst = 1'b0;
    for (int w = 0; w < 32; w++) begin
      tbl[w].in_r  = 16'(200 + w);
      tbl[w].in_i  = 16'(300 + w);
      tbl[w].exp_r = 16'(200 + br(w));
      tbl[w].exp_i = 16'(300 + br(w));
    end
    feed_tbl(e);
    verify("midframe", e);
    if (cap.size() == 32) begin
      chk("midframe bin0 re", cap[0].r, 200);
      chk("midframe bin1 re", cap[1].r, 216);
    end
    cap.delete();

    // Reset while bin 5 is on the output.
    for (int w = 0; w < 32; w++) send(1'b1, 16'(400 + w), 16'(700 + w), e);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midread valid_o", valid_o, 0);
    chk("midread frame_start_o", frame_start_o, 0);
    chk("midread index_o", index_o, 0);
    chk("midread data_out_r", data_out_r, 0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midread beat count", cap.size(), 6);
    if (cap.size() >= 6) begin
      chk("midread bin5 index", cap[5].idx, 5);
      chk("midread bin5 re", cap[5].r, 420);
    end
    cap.delete();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
